// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter between WB and MDU with pending-write FIFO and RAW hazard flags
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        hazard1,
  output logic        hazard2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ST_W  = $clog2(MAX_WAIT + 1);

  logic [4:0]       fifo_reg  [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve;

  logic fifo_empty;
  logic fifo_full;
  logic grant_head;
  logic grant_wb;
  logic grant_mdu;
  logic enqueue;
  logic fifo_hit1;
  logic fifo_hit2;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign mdu_ready  = !fifo_full;
  // Stall is derived from registered state only, so it never depends on this cycle's requests.
  assign pipe_stall = (starve == ST_W'(MAX_WAIT));

  // Fixed-priority grant: forced drain, then WB, then queued MDU, then MDU bypass.
  always_comb begin
    grant_head = !fifo_empty && (pipe_stall || !wb_valid);
    grant_wb   = !pipe_stall && wb_valid;
    grant_mdu  = !pipe_stall && !wb_valid && fifo_empty && mdu_valid;
    // r0 writes are consumed without occupying a slot.
    enqueue    = mdu_valid && mdu_ready && !grant_mdu && (mdu_reg != 5'd0);
  end

  // RAW check of both read ports against valid queued writes.
  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && (fifo_reg[i] == ReadRegister1)) fifo_hit1 = 1'b1;
      if (fifo_valid[i] && (fifo_reg[i] == ReadRegister2)) fifo_hit2 = 1'b1;
    end
  end

  assign hazard1 = (ReadRegister1 != 5'd0) &&
                   (fifo_hit1 || (RegWrite && (WriteRegister == ReadRegister1)));
  assign hazard2 = (ReadRegister2 != 5'd0) &&
                   (fifo_hit2 || (RegWrite && (WriteRegister == ReadRegister2)));

  // Register the granted write onto the register-file port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      RegWrite <= 1'b0;
      if (grant_head) begin
        // A squashed head is popped silently.
        RegWrite      <= fifo_valid[head];
        WriteRegister <= fifo_reg[head];
        WriteData     <= fifo_data[head];
      end else if (grant_wb) begin
        RegWrite      <= (wb_reg != 5'd0);
        WriteRegister <= wb_reg;
        WriteData     <= wb_data;
      end else if (grant_mdu) begin
        RegWrite      <= (mdu_reg != 5'd0);
        WriteRegister <= mdu_reg;
        WriteData     <= mdu_data;
      end
    end
  end

  // Queue payload storage; validity is tracked separately so it needs no reset.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      fifo_reg[tail]  <= mdu_reg;
      fifo_data[tail] <= mdu_data;
    end
  end

  // Queue control: WAW squash, pop on head grant, push at tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_valid <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      if (grant_wb && (wb_reg != 5'd0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_reg[i] == wb_reg) fifo_valid[i] <= 1'b0;
        end
      end
      if (grant_head) begin
        fifo_valid[head] <= 1'b0;
        head             <= head + PTR_W'(1);
      end
      if (enqueue) begin
        fifo_valid[tail] <= 1'b1;
        tail             <= tail + PTR_W'(1);
      end
      if (enqueue && !grant_head) begin
        count <= count + CNT_W'(1);
      end else if (!enqueue && grant_head) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Starvation counter: counts WB wins over a waiting queue, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (fifo_empty || grant_head) begin
      starve <= '0;
    end else if (grant_wb && (starve != ST_W'(MAX_WAIT))) begin
      starve <= starve + ST_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_reg = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        pipe_stall;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic        hazard1;
  logic        hazard2;

  int checks = 0;
  int passes = 0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wv; logic [4:0] wr; logic [31:0] wd;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic [4:0] r1; logic [4:0] r2;
    logic e_ready; logic e_stall; logic e_h1; logic e_h2;
    logic e_rw; logic [4:0] e_wr; logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic [4:0] r; logic [31:0] d; bit v;
  } ent_t;

  vec_t vecs[$];

  ent_t        mq[$];
  int          m_starve;
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic vec_t mk(logic wv, logic [4:0] wr, logic [31:0] wd,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic [4:0] r1, logic [4:0] r2,
                              logic er, logic es, logic eh1, logic eh2,
                              logic erw, logic [4:0] ewr, logic [31:0] ewd);
    vec_t v;
    v.wv = wv; v.wr = wr; v.wd = wd; v.mv = mv; v.mr = mr; v.md = md;
    v.r1 = r1; v.r2 = r2; v.e_ready = er; v.e_stall = es; v.e_h1 = eh1; v.e_h2 = eh2;
    v.e_rw = erw; v.e_wr = ewr; v.e_wd = ewd;
    return v;
  endfunction

  task automatic drive(logic wv, logic [4:0] wr, logic [31:0] wd,
                       logic mv, logic [4:0] mr, logic [31:0] md,
                       logic [4:0] r1, logic [4:0] r2);
    wb_valid = wv; wb_reg = wr; wb_data = wd;
    mdu_valid = mv; mdu_reg = mr; mdu_data = md;
    ReadRegister1 = r1; ReadRegister2 = r2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_starve = 0; m_rw = 0; m_wr = '0; m_wd = '0;
  endtask

  function automatic bit m_haz(logic [4:0] rr);
    if (rr == 5'd0) return 1'b0;
    foreach (mq[k]) if (mq[k].v && mq[k].r == rr) return 1'b1;
    return m_rw && (m_wr == rr);
  endfunction

  // Reference: one clock of arbitration applied to the queue model.
  task automatic model_step(logic wv, logic [4:0] wr, logic [31:0] wd,
                            logic mv, logic [4:0] mr, logic [31:0] md);
    int   sz;
    bit   stall, ready, popped, wbg, byp;
    ent_t h;
    ent_t n;
    sz = mq.size();
    stall = (m_starve == MAX_WAIT);
    ready = (sz < DEPTH);
    popped = 0; wbg = 0; byp = 0;
    m_rw = 0;
    if (stall) begin
      if (sz > 0) begin
        h = mq.pop_front(); popped = 1;
        if (h.v) begin m_rw = 1; m_wr = h.r; m_wd = h.d; end
      end
    end else if (wv) begin
      wbg = 1;
      if (wr != 0) begin
        m_rw = 1; m_wr = wr; m_wd = wd;
        foreach (mq[k]) if (mq[k].r == wr) mq[k].v = 0;
      end
    end else if (sz > 0) begin
      h = mq.pop_front(); popped = 1;
      if (h.v) begin m_rw = 1; m_wr = h.r; m_wd = h.d; end
    end else if (mv) begin
      byp = 1;
      if (mr != 0) begin m_rw = 1; m_wr = mr; m_wd = md; end
    end
    if (sz == 0 || popped) m_starve = 0;
    else if (wbg && m_starve < MAX_WAIT) m_starve++;
    if (mv && ready && !byp && mr != 0) begin
      n.r = mr; n.d = md; n.v = 1;
      mq.push_back(n);
    end
  endtask

  initial begin
    // Reset state while reset is held.
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    #3;
    chk("reset_regwrite", RegWrite, 0);
    chk("reset_wreg", WriteRegister, 0);
    chk("reset_wdata", WriteData, 0);
    chk("reset_mdu_ready", mdu_ready, 1);
    chk("reset_pipe_stall", pipe_stall, 0);
    chk("reset_hazard1", hazard1, 0);
    chk("reset_hazard2", hazard2, 0);
    @(negedge clk);
    reset = 1'b0;

    //                 wv wr  wd            mv mr  md     r1  r2  rdy stl h1 h2 rw wr  wd
    vecs.push_back(mk(1, 5,  32'hAAAA0001, 0, 0,  0,     0,  0,  1,  0,  0, 0, 1, 5,  32'hAAAA0001));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     5,  3,  1,  0,  1, 0, 0, 0,  0));
    vecs.push_back(mk(1, 3,  32'h33,       1, 7,  32'h77,7,  3,  1,  0,  0, 0, 1, 3,  32'h33));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     7,  3,  1,  0,  1, 1, 1, 7,  32'h77));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     7,  0,  1,  0,  1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            1, 0,  32'h55,0,  7,  1,  0,  0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     0,  0,  1,  0,  0, 0, 0, 0,  0));
    vecs.push_back(mk(1, 1,  32'h11,       1, 9,  32'h1, 0,  0,  1,  0,  0, 0, 1, 1,  32'h11));
    vecs.push_back(mk(1, 9,  32'h2,        0, 0,  0,     9,  0,  1,  0,  1, 0, 1, 9,  32'h2));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     9,  1,  1,  0,  1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     9,  0,  1,  0,  0, 0, 0, 0,  0));
    vecs.push_back(mk(1, 2,  32'h1002,     1, 10, 32'hA0,0,  0,  1,  0,  0, 0, 1, 2,  32'h1002));
    vecs.push_back(mk(1, 2,  32'h1003,     1, 11, 32'hB0,10, 0,  1,  0,  1, 0, 1, 2,  32'h1003));
    vecs.push_back(mk(1, 2,  32'h1004,     1, 12, 32'hC0,10, 11, 0,  0,  1, 1, 1, 2,  32'h1004));
    vecs.push_back(mk(1, 2,  32'h1005,     1, 12, 32'hC0,10, 11, 0,  0,  1, 1, 1, 2,  32'h1005));
    vecs.push_back(mk(1, 2,  32'h1006,     1, 12, 32'hC0,10, 11, 0,  0,  1, 1, 1, 2,  32'h1006));
    vecs.push_back(mk(1, 2,  32'h1007,     1, 12, 32'hC0,10, 11, 0,  1,  1, 1, 1, 10, 32'hA0));
    vecs.push_back(mk(1, 2,  32'h1008,     1, 12, 32'hC0,10, 12, 1,  0,  1, 0, 1, 2,  32'h1008));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     11, 12, 0,  0,  1, 1, 1, 11, 32'hB0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     11, 12, 1,  0,  1, 1, 1, 12, 32'hC0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     11, 12, 1,  0,  0, 1, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,     0,  12, 1,  0,  0, 0, 0, 0,  0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wv, vecs[i].wr, vecs[i].wd, vecs[i].mv, vecs[i].mr, vecs[i].md,
            vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("row%0d_mdu_ready", i), mdu_ready, vecs[i].e_ready);
      chk($sformatf("row%0d_pipe_stall", i), pipe_stall, vecs[i].e_stall);
      chk($sformatf("row%0d_hazard1", i), hazard1, vecs[i].e_h1);
      chk($sformatf("row%0d_hazard2", i), hazard2, vecs[i].e_h2);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_regwrite", i), RegWrite, vecs[i].e_rw);
      if (vecs[i].e_rw) begin
        chk($sformatf("row%0d_wreg", i), WriteRegister, vecs[i].e_wr);
        chk($sformatf("row%0d_wdata", i), WriteData, vecs[i].e_wd);
      end
    end

    // Reset asserted with two MDU writes queued behind WB.
    @(negedge clk); drive(1, 4, 32'h400, 1, 13, 32'hD0, 0, 0);
    @(negedge clk); drive(1, 4, 32'h401, 1, 14, 32'hE0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 13, 14);
    #1;
    chk("midrst_pre_hazard1", hazard1, 1);
    chk("midrst_pre_ready", mdu_ready, 0);
    reset = 1'b1;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_ready", mdu_ready, 1);
    chk("midrst_stall", pipe_stall, 0);
    chk("midrst_hazard1", hazard1, 0);
    chk("midrst_hazard2", hazard2, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_post%0d_regwrite", k), RegWrite, 0);
      chk($sformatf("midrst_post%0d_hazard1", k), hazard1, 0);
    end

    // Randomised traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic wv, mv;
      logic [4:0] wr, mr, r1, r2;
      logic [31:0] wd, md;
      int thr;
      thr = ((i / 16) % 2) ? 9 : 5;
      wv = ($urandom_range(0, 9) < thr);
      wr = 5'($urandom_range(0, 7));
      wd = $urandom;
      mv = ($urandom_range(0, 9) < 5);
      mr = 5'($urandom_range(0, 7));
      md = $urandom;
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      @(negedge clk);
      drive(wv, wr, wd, mv, mr, md, r1, r2);
      #1;
      chk($sformatf("rnd%0d_mdu_ready", i), mdu_ready, (mq.size() < DEPTH));
      chk($sformatf("rnd%0d_pipe_stall", i), pipe_stall, (m_starve == MAX_WAIT));
      chk($sformatf("rnd%0d_hazard1", i), hazard1, m_haz(r1));
      chk($sformatf("rnd%0d_hazard2", i), hazard2, m_haz(r2));
      model_step(wv, wr, wd, mv, mr, md);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_regwrite", i), RegWrite, m_rw);
      if (m_rw) begin
        chk($sformatf("rnd%0d_wreg", i), WriteRegister, m_wr);
        chk($sformatf("rnd%0d_wdata", i), WriteData, m_wd);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: the pipeline writeback stage (WB) and the multi-cycle multiply/divide unit (MDU).
- WB has priority. Losing MDU writes are held in a small FIFO, drained on idle WB cycles, with a starvation guard that stalls the pipeline.
- Flags read-after-write hazards for the ID-stage read ports against writes not yet committed.
- Sits between the WB/MDU outputs and the register file write inputs.

Parameters:
- DEPTH, 2, MDU pending-write FIFO entries (power of 2, ≥2).
- MAX_WAIT, 4, consecutive blocked cycles with FIFO non-empty before pipe_stall asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  WB write request.
- wb_reg  in  5  WB destination register.
- wb_data  in  32  WB write data.
- mdu_valid  in  1  MDU write request.
- mdu_reg  in  5  MDU destination register.
- mdu_data  in  32  MDU write data.
- mdu_ready  out  1  MDU request accepted this cycle when high.
- pipe_stall  out  1  pipeline must hold; the WB request is ignored this cycle.
- RegWrite  out  1  register file write enable (registered).
- WriteRegister  out  5  register file write address (registered).
- WriteData  out  32  register file write data (registered).
- ReadRegister1  in  5  ID read address 1.
- ReadRegister2  in  5  ID read address 2.
- hazard1  out  1  ReadRegister1 has an uncommitted write.
- hazard2  out  1  ReadRegister2 has an uncommitted write.

Behaviour:
- Reset, asynchronous:
  - FIFO emptied, all entries invalid.
  - Starvation counter = 0.
  - RegWrite = 0, WriteRegister = 0, WriteData = 0.
  - pipe_stall = 0, mdu_ready = 1, hazards = 0.
  - Reset mid-operation discards all pending writes.
- Write port: RegWrite/WriteRegister/WriteData are updated on every clk edge from the grant; 1-cycle latency from request to port. RegWrite = 0 when nothing is granted.
- Grant priority each cycle:
  1. pipe_stall = 1: FIFO head.
  2. wb_valid = 1: WB.
  3. FIFO non-empty: FIFO head.
  4. mdu_valid = 1 and FIFO empty: MDU direct (bypass, no enqueue).
  5. Otherwise: idle.
- mdu_ready = !full (combinational from FIFO state).
  - An MDU request that is accepted but not granted is enqueued at the tail.
  - A full FIFO never enqueues, even while dequeuing the same cycle.
- Dequeue and enqueue in the same cycle are allowed; occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy uses a count register, width clog2(DEPTH)+1.
- Register 0:
  - Any request with reg = 0 is accepted and consumed but produces RegWrite = 0.
  - reg-0 requests are never enqueued.
  - reg-0 reads never flag hazards.
- WAW squash: when WB is granted and wb_reg matches valid FIFO entries, those entries are invalidated. An invalid entry at the head is dropped (popped with RegWrite = 0).
- Starvation counter:
  - Increments when the FIFO is non-empty and WB is granted.
  - Clears when the FIFO head is granted or the FIFO is empty.
  - Saturates at MAX_WAIT.
  - pipe_stall = (counter == MAX_WAIT), registered-state derived, and lasts exactly one cycle per drain.
- Hazards (combinational): hazardN = 1 when ReadRegisterN != 0 and either matches:
  - a valid FIFO entry, or
  - the WriteRegister currently held with RegWrite = 1 (not yet written into the register file).

Test Plan:
- Reset asserted mid-burst with 2 entries queued -> FIFO empty, RegWrite = 0, mdu_ready = 1 immediately; no later writes of the queued data.
- wb_valid reg 5 = 0xAAAA0001 alone -> next cycle RegWrite = 1, WriteRegister = 5, WriteData = 0xAAAA0001; hazard1 = 1 when ReadRegister1 = 5 during that cycle.
- WB and MDU simultaneous (WB r3, MDU r7 = 0x77) -> WB written first; r7 enqueued, hazard on 7; r7 written on the first wb_valid = 0 cycle.
- Three MDU requests during continuous WB with DEPTH = 2 -> third request sees mdu_ready = 0; after 4 blocked cycles pipe_stall = 1 for one cycle and the head is written.
- FIFO holds r9 = 0x1, then WB writes r9 = 0x2 -> entry squashed; final register-file write to r9 is 0x2 only.
- MDU write to r0 with FIFO empty -> mdu_ready = 1, RegWrite stays 0, no enqueue, hazard1 = 0 for ReadRegister1 = 0.
